// File: rtl/cfo_calc_sched_pkg.sv
// Shared types and default constants for the CFO calculator scheduler.
package cfo_sched_pkg;

  localparam int C_DW_DEF      = 32;
  localparam int CFO_DW_DEF    = 20;
  localparam int N_REQ_DEF     = 3;
  localparam int TIMEOUT_DEF   = 64;
  localparam int AVG_SHIFT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    DELIVER  = 2'd3
  } sched_state_e;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cfo_calc_sched_if.sv
// Requester and calculator channels of the CFO scheduler; _i/_o suffixes are seen from the scheduler.
interface cfo_calc_sched_if
  import cfo_sched_pkg::*;
#(
  parameter int C_DW   = C_DW_DEF,
  parameter int CFO_DW = CFO_DW_DEF,
  parameter int N_REQ  = N_REQ_DEF
);
  logic [N_REQ*C_DW-1:0] req_C0_i;
  logic [N_REQ*C_DW-1:0] req_C1_i;
  logic [N_REQ-1:0]      req_valid_i;
  logic [N_REQ-1:0]      req_ready_o;
  logic [C_DW-1:0]       calc_C0_o;
  logic [C_DW-1:0]       calc_C1_o;
  logic                  calc_valid_o;
  logic [CFO_DW-1:0]     calc_CFO_i;
  logic                  calc_valid_i;

  modport slave (
    input  req_C0_i, req_C1_i, req_valid_i, calc_CFO_i, calc_valid_i,
    output req_ready_o, calc_C0_o, calc_C1_o, calc_valid_o
  );

  modport master (
    output req_C0_i, req_C1_i, req_valid_i, calc_CFO_i, calc_valid_i,
    input  req_ready_o, calc_C0_o, calc_C1_o, calc_valid_o
  );
endinterface

// File: rtl/cfo_calc_sched_arb.sv
// Round-robin picker: first set request bit at or after ptr_i, wrapping modulo N. Purely combinational.
module rr_arbiter #(
  parameter int  N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          any_o
);

  // Scan a doubled index range so the wrap needs no modulo on a variable index.
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!any_o && i >= int'(ptr_i) && i < int'(ptr_i) + N && req_i[i % N]) begin
        any_o = 1'b1;
        gnt_o = IW'(i % N);
      end
    end
  end

endmodule

// File: rtl/cfo_calc_sched.sv
// Shares one CFO calculator among N_REQ correlator channels; one request in flight, result 3 cycles + calc latency after capture.
// Optional per-channel CFO averaging under macro CFO_SCHED_AVG_EN; requesters are held off only by their own full slot.
module cfo_calc_sched
  import cfo_sched_pkg::*;
#(
  parameter int  C_DW      = C_DW_DEF,
  parameter int  CFO_DW    = CFO_DW_DEF,
  parameter int  N_REQ     = N_REQ_DEF,
  parameter int  TIMEOUT   = TIMEOUT_DEF,
  parameter int  AVG_SHIFT = AVG_SHIFT_DEF,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  cfo_calc_sched_if.slave   bus,
  output logic [CFO_DW-1:0] CFO_o,
  output logic [IDW-1:0]    CFO_id_o,
  output logic              valid_o,
  output logic              timeout_o,
  output logic              busy_o
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  if (N_REQ < 2 || N_REQ > 8 || AVG_SHIFT < 0 || AVG_SHIFT >= CFO_DW) begin : g_cfg_bad
    $error("cfo_calc_sched: unsupported N_REQ/AVG_SHIFT");
  end

  sched_state_e      state_q, state_d;
  logic [N_REQ-1:0]  full_q;
  logic [C_DW-1:0]   c0_q [N_REQ];
  logic [C_DW-1:0]   c1_q [N_REQ];
  logic [IDW-1:0]    rr_ptr_q, grant_q, arb_idx;
  logic              arb_any;
  logic [CNT_W-1:0]  cnt_q;
  logic [CFO_DW-1:0] res_q, dlv_cfo;
  logic [C_DW-1:0]   calc_c0_q, calc_c1_q;
  logic              valid_q, timeout_q, expire;
  logic [CFO_DW-1:0] cfo_q;
  logic [IDW-1:0]    id_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i (full_q),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_idx),
    .any_o (arb_any)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A result arriving in the expiry cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    expire  = 1'b0;
    case (state_q)
      IDLE:     if (arb_any) state_d = ISSUE;
      ISSUE:    state_d = WAIT_RES;
      WAIT_RES: begin
        if (bus.calc_valid_i) begin
          state_d = DELIVER;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          expire  = 1'b1;
        end
      end
      DELIVER:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q    <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      calc_c0_q <= '0;
      calc_c1_q <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cfo_q     <= '0;
      id_q      <= '0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        if (bus.req_valid_i[k] && !full_q[k]) begin
          full_q[k] <= 1'b1;
          c0_q[k]   <= bus.req_C0_i[k*C_DW +: C_DW];
          c1_q[k]   <= bus.req_C1_i[k*C_DW +: C_DW];
        end
      end
      if (state_q == IDLE && arb_any) begin
        grant_q   <= arb_idx;
        calc_c0_q <= c0_q[arb_idx];
        calc_c1_q <= c1_q[arb_idx];
      end
      if (state_q == ISSUE)         cnt_q <= '0;
      else if (state_q == WAIT_RES) cnt_q <= cnt_q + 1'b1;
      if (state_q == WAIT_RES && bus.calc_valid_i) res_q <= bus.calc_CFO_i;
      // The granted slot is always full, so this never collides with a capture.
      if (expire || state_q == DELIVER) begin
        full_q[grant_q] <= 1'b0;
        rr_ptr_q        <= IDW'(wrap_inc(int'(grant_q), N_REQ));
      end
      if (expire) timeout_q <= 1'b1;
      if (state_q == DELIVER) begin
        valid_q <= 1'b1;
        id_q    <= grant_q;
        cfo_q   <= dlv_cfo;
      end
    end
  end

`ifdef CFO_SCHED_AVG_EN
  logic signed [CFO_DW-1:0] avg_q [N_REQ];
  logic signed [CFO_DW-1:0] avg_cur, avg_diff;

  // Difference wraps in CFO_DW bits so averaging across the +-pi seam stays on the short arc.
  always_comb begin
    avg_cur  = avg_q[grant_q];
    avg_diff = res_q - avg_cur;
    dlv_cfo  = avg_cur + (avg_diff >>> AVG_SHIFT);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < N_REQ; k++) avg_q[k] <= '0;
    end else if (state_q == DELIVER) begin
      avg_q[grant_q] <= dlv_cfo;
    end
  end
`else
  assign dlv_cfo = res_q;
`endif

  assign bus.req_ready_o  = ~full_q;
  assign bus.calc_valid_o = (state_q == ISSUE);
  assign bus.calc_C0_o    = calc_c0_q;
  assign bus.calc_C1_o    = calc_c1_q;
  assign CFO_o            = cfo_q;
  assign CFO_id_o         = id_q;
  assign valid_o          = valid_q;
  assign timeout_o        = timeout_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: doc/cfo_calc_sched.md
CFO_CALC_SCHED -- requirements
Module: cfo_calc_sched

Interface
REQ-001 Parameter C_DW, 32, width of one complex correlation sample; imaginary part in the upper half, real part in the lower half.
REQ-002 Parameter CFO_DW, 20, signed width of a normalized CFO result.
REQ-003 Parameter N_REQ, 3, number of requesters, one per N_ID_2 PSS correlator channel; range 2..8.
REQ-004 Parameter TIMEOUT, 64, maximum number of cycles to wait for the calculator result.
REQ-005 Parameter AVG_SHIFT, 3, exponent of the averaging weight (weight = 1/2^AVG_SHIFT).
REQ-006 clk_i  in  1  single clock; every port is synchronous to it.
REQ-007 reset_i  in  1  synchronous, active-high reset.
REQ-008 req_C0_i  in  N_REQ*C_DW  C0 of each requester; slice k belongs to requester k.
REQ-009 req_C1_i  in  N_REQ*C_DW  C1 of each requester; same slicing as req_C0_i.
REQ-010 req_valid_i  in  N_REQ  one request bit per requester.
REQ-011 req_ready_o  out  N_REQ  high while that requester's holding slot is empty.
REQ-012 calc_C0_o, calc_C1_o  out  C_DW each  operand pair driven to the shared CFO calculator.
REQ-013 calc_valid_o  out  1  single-cycle issue strobe to the calculator.
REQ-014 calc_CFO_i  in  CFO_DW  calculator result.
REQ-015 calc_valid_i  in  1  calculator result strobe.
REQ-016 CFO_o  out  CFO_DW  result routed back to the requester that issued it.
REQ-017 CFO_id_o  out  $clog2(N_REQ)  index of the owning requester.
REQ-018 valid_o  out  1  single-cycle result strobe.
REQ-019 timeout_o  out  1  single-cycle pulse when an issued request is dropped.
REQ-020 busy_o  out  1  high in every state except IDLE.

Function
REQ-021 A requester transfers a request when req_valid_i[k] and req_ready_o[k] are both high in the same cycle; the C0/C1 pair is captured into slot k on that edge.
REQ-022 req_ready_o[k] is derived combinationally from the registered slot-full flag only; a slot freed at edge T can accept a new request at edge T+1 at the earliest.
REQ-023 The block has four states: IDLE, ISSUE, WAIT_RES and DELIVER; at most one request is in flight, because the calculator has no ready signal.
REQ-024 In IDLE, when any slot is full, the arbiter grants the first full slot at or after rr_ptr (round-robin, wrapping modulo N_REQ) and the block moves to ISSUE.
REQ-025 In ISSUE, the block drives calc_valid_o=1 with the granted pair for exactly one cycle, clears the timeout counter and moves to WAIT_RES.
REQ-026 In WAIT_RES, calc_valid_i latches calc_CFO_i and the block moves to DELIVER.
REQ-027 In WAIT_RES, when the counter reaches TIMEOUT-1 without calc_valid_i, the block pulses timeout_o, frees the granted slot, sets rr_ptr to grant+1 and returns to IDLE.
REQ-028 In DELIVER, the block pulses valid_o with CFO_o and CFO_id_o=grant, frees the slot, sets rr_ptr to grant+1 (mod N_REQ) and returns to IDLE.
REQ-029 Minimum latency from request capture to valid_o is 3 cycles plus the calculator latency.
REQ-030 calc_valid_i outside WAIT_RES is ignored and changes no state.
REQ-031 calc_valid_i arriving in the same cycle as timeout expiry counts as a result: the block goes to DELIVER and timeout_o is not pulsed.
REQ-032 calc_C0_o and calc_C1_o hold the last issued pair while calc_valid_o is low.

Reset
REQ-033 While reset_i is high: all slots empty, state=IDLE, rr_ptr=0, counter=0, averages=0, and valid_o, timeout_o, calc_valid_o, CFO_o, CFO_id_o all 0.
REQ-034 Reset asserted mid-operation drops any in-flight request; a late calc_valid_i after reset is ignored per REQ-030.

Configuration
REQ-035 With macro CFO_SCHED_AVG_EN defined, each requester keeps an average avg[k] updated in DELIVER as avg[k] += (x - avg[k]) >>> AVG_SHIFT, where x = calc_CFO_i.
REQ-036 In that update the difference x - avg[k] is computed in CFO_DW bits with two's-complement wrap, so the +-pi phase crossing averages correctly; CFO_o outputs the updated avg[k].
REQ-037 Without CFO_SCHED_AVG_EN, CFO_o outputs the raw calculator result and no averaging registers exist.

Structure
REQ-038 Package cfo_sched_pkg holds the state enum and the default constants for C_DW, CFO_DW, TIMEOUT and AVG_SHIFT.
REQ-039 The round-robin grant logic is a sub-module rr_arbiter (inputs: request vector and pointer; outputs: grant index and any-request flag).

Verification
REQ-040 Single request: slot0 gets C0=0x00001000, calculator returns 0x01000 after 5 cycles -> valid_o with CFO_o=0x01000, CFO_id_o=0, and exactly one calc_valid_o pulse.
REQ-041 All 3 slots loaded in the same cycle with rr_ptr=0 -> results in order 0, 1, 2; a re-fill of slot0 then issues after slot2.
REQ-042 Calculator silent -> timeout_o pulses TIMEOUT+1 cycles after calc_valid_o, slot freed, next slot issued.
REQ-043 Spurious calc_valid_i in IDLE -> no valid_o; calc_valid_i in the expiry cycle -> valid_o and no timeout_o.
REQ-044 Reset asserted in WAIT_RES -> all outputs 0 next cycle and req_ready_o all ones.
REQ-045 With CFO_SCHED_AVG_EN, AVG_SHIFT=1: results 0x7FF00 then 0x80100 -> second output wraps near +-pi, not near 0.
